// File: rtl/bob_buf_pkg.sv
// Shared types and widths for the branch order buffer beside the tournament predictor.
package bob_buf_pkg;

    localparam int PC_W        = 64;
    localparam int BOB_BHR_W   = 12;
    localparam int BOB_LHIST_W = 10;
    localparam int BOB_ENTRY_W = PC_W + BOB_BHR_W + BOB_LHIST_W + 2;

    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic [BOB_BHR_W-1:0]   bhr;
        logic [BOB_LHIST_W-1:0] lochist;
        logic                   ch_we;
        logic                   ch_brdir;
    } bob_entry_t;

endpackage

// File: rtl/bob_buf_store.sv
// Entry storage for the branch order buffer: one write port, one asynchronous read port.
module bob_store
    import bob_buf_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [LOG_DEPTH-1:0]   waddr,
    input  logic [BOB_ENTRY_W-1:0] wdata,
    input  logic [LOG_DEPTH-1:0]   raddr,
    output logic [BOB_ENTRY_W-1:0] rdata
);

    logic [BOB_ENTRY_W-1:0] mem [DEPTH];

    // Data flops carry no reset; the owner masks reads while the buffer is empty.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bob_buf.sv
// Branch order buffer: program-order FIFO of predictor state, allocated at F1 and popped at retire.
module bob_buf
    import bob_buf_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LOG_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alloc_vld_i,
    input  logic [PC_W-1:0]        alloc_pc_i,
    input  logic [BOB_BHR_W-1:0]   alloc_bhr_i,
    input  logic [BOB_LHIST_W-1:0] alloc_lochist_i,
    input  logic                   alloc_ch_we_i,
    input  logic                   alloc_ch_brdir_i,
    output logic                   alloc_rdy_o,
    output logic [LOG_DEPTH-1:0]   alloc_tag_o,
    input  logic                   rt_vld_i,
    input  logic                   pipctl_flush_rt_i,
    output logic                   bob_valid_r_o,
    output logic [PC_W-1:0]        bob_pc_r_o,
    output logic [BOB_BHR_W-1:0]   bob_bhr_r_o,
    output logic [BOB_LHIST_W-1:0] bob_lochist_o,
    output logic                   bob_ch_we_o,
    output logic                   bob_ch_brdir_o,
    output logic [LOG_DEPTH:0]     bob_count_o
);

    localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH+1)'(1);

    logic [LOG_DEPTH:0]     head;
    logic [LOG_DEPTH:0]     tail;
    logic                   empty;
    logic                   full;
    logic                   do_alloc;
    logic                   do_retire;
    bob_entry_t             wr_entry;
    bob_entry_t             rd_entry;
    logic [BOB_ENTRY_W-1:0] rd_bits;

    // The MSB of each pointer is a wrap bit, so equal indices disambiguate full from empty.
    assign empty = (head == tail);
    assign full  = (head[LOG_DEPTH-1:0] == tail[LOG_DEPTH-1:0]) &&
                   (head[LOG_DEPTH] != tail[LOG_DEPTH]);

    assign alloc_rdy_o = !full || (rt_vld_i && !pipctl_flush_rt_i);
    assign alloc_tag_o = tail[LOG_DEPTH-1:0];
    assign bob_count_o = tail - head;

    // An allocate into an empty buffer cannot be retired in the same cycle; flush discards both.
    assign do_alloc  = alloc_vld_i && alloc_rdy_o && !pipctl_flush_rt_i;
    assign do_retire = rt_vld_i && !empty;

    always_comb begin
        wr_entry          = '0;
        wr_entry.pc       = alloc_pc_i;
        wr_entry.bhr      = alloc_bhr_i;
        wr_entry.lochist  = alloc_lochist_i;
        wr_entry.ch_we    = alloc_ch_we_i;
        wr_entry.ch_brdir = alloc_ch_brdir_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
        end else if (pipctl_flush_rt_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_retire) begin
                head <= head + PTR_ONE;
            end
            if (do_alloc) begin
                tail <= tail + PTR_ONE;
            end
        end
    end

    bob_store #(
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_store (
        .clock (clock),
        .we    (do_alloc),
        .waddr (tail[LOG_DEPTH-1:0]),
        .wdata (wr_entry),
        .raddr (head[LOG_DEPTH-1:0]),
        .rdata (rd_bits)
    );

    assign rd_entry = bob_entry_t'(rd_bits);

    // Head data is forced to zero while empty, since the storage itself is never cleared.
    assign bob_valid_r_o  = !empty;
    assign bob_pc_r_o     = empty ? '0   : rd_entry.pc;
    assign bob_bhr_r_o    = empty ? '0   : rd_entry.bhr;
    assign bob_lochist_o  = empty ? '0   : rd_entry.lochist;
    assign bob_ch_we_o    = empty ? 1'b0 : rd_entry.ch_we;
    assign bob_ch_brdir_o = empty ? 1'b0 : rd_entry.ch_brdir;

endmodule

// File: tb/tb_bob_buf.sv
// Directed self-checking bench for bob_buf: ordering, full/empty edges, flush, wrap and async reset.
module tb_bob_buf;
    import bob_buf_pkg::*;

    logic                   clock;
    logic                   reset_n;
    logic                   alloc_vld_i;
    logic [PC_W-1:0]        alloc_pc_i;
    logic [BOB_BHR_W-1:0]   alloc_bhr_i;
    logic [BOB_LHIST_W-1:0] alloc_lochist_i;
    logic                   alloc_ch_we_i;
    logic                   alloc_ch_brdir_i;
    logic                   alloc_rdy_o;
    logic [3:0]             alloc_tag_o;
    logic                   rt_vld_i;
    logic                   pipctl_flush_rt_i;
    logic                   bob_valid_r_o;
    logic [PC_W-1:0]        bob_pc_r_o;
    logic [BOB_BHR_W-1:0]   bob_bhr_r_o;
    logic [BOB_LHIST_W-1:0] bob_lochist_o;
    logic                   bob_ch_we_o;
    logic                   bob_ch_brdir_o;
    logic [4:0]             bob_count_o;

    int pass_cnt;
    int check_cnt;
    bob_entry_t model_q [$];
    bob_entry_t exp_e;
    bob_entry_t new_e;

    bob_buf #(.DEPTH(16), .LOG_DEPTH(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .alloc_vld_i       (alloc_vld_i),
        .alloc_pc_i        (alloc_pc_i),
        .alloc_bhr_i       (alloc_bhr_i),
        .alloc_lochist_i   (alloc_lochist_i),
        .alloc_ch_we_i     (alloc_ch_we_i),
        .alloc_ch_brdir_i  (alloc_ch_brdir_i),
        .alloc_rdy_o       (alloc_rdy_o),
        .alloc_tag_o       (alloc_tag_o),
        .rt_vld_i          (rt_vld_i),
        .pipctl_flush_rt_i (pipctl_flush_rt_i),
        .bob_valid_r_o     (bob_valid_r_o),
        .bob_pc_r_o        (bob_pc_r_o),
        .bob_bhr_r_o       (bob_bhr_r_o),
        .bob_lochist_o     (bob_lochist_o),
        .bob_ch_we_o       (bob_ch_we_o),
        .bob_ch_brdir_o    (bob_ch_brdir_o),
        .bob_count_o       (bob_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) begin
            pass_cnt++;
        end else begin
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [63:0] pc, input logic [11:0] bhr,
                                 input logic [9:0] lh, input logic we, input logic dir,
                                 input logic rt, input logic fl);
        alloc_vld_i       = av;
        alloc_pc_i        = pc;
        alloc_bhr_i       = bhr;
        alloc_lochist_i   = lh;
        alloc_ch_we_i     = we;
        alloc_ch_brdir_i  = dir;
        rt_vld_i          = rt;
        pipctl_flush_rt_i = fl;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        reset_n   = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("reset_valid", 64'(bob_valid_r_o), 0);
        checkOutput("reset_rdy",   64'(alloc_rdy_o), 1);
        checkOutput("reset_tag",   64'(alloc_tag_o), 0);
        checkOutput("reset_count", 64'(bob_count_o), 0);
        checkOutput("reset_pc",    bob_pc_r_o, 0);
        #9;
        reset_n = 1'b1;
        stepClock();

        // Three allocates, then in-order retirement
        applyStimulus(1, 64'h1000, 12'h001, 10'h3ff, 1, 1, 0, 0);
        stepClock();
        applyStimulus(1, 64'h1004, 12'h002, 10'h011, 0, 1, 0, 0);
        stepClock();
        applyStimulus(1, 64'h1008, 12'h003, 10'h022, 1, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_count",   64'(bob_count_o), 3);
        checkOutput("t1_tag",     64'(alloc_tag_o), 3);
        checkOutput("t1_valid",   64'(bob_valid_r_o), 1);
        checkOutput("t1_pc0",     bob_pc_r_o, 64'h1000);
        checkOutput("t1_bhr0",    64'(bob_bhr_r_o), 12'h001);
        checkOutput("t1_lh0",     64'(bob_lochist_o), 10'h3ff);
        checkOutput("t1_we0",     64'(bob_ch_we_o), 1);
        checkOutput("t1_dir0",    64'(bob_ch_brdir_o), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("t1_pc0_pre", bob_pc_r_o, 64'h1000);
        stepClock();
        checkOutput("t1_pc1",     bob_pc_r_o, 64'h1004);
        checkOutput("t1_bhr1",    64'(bob_bhr_r_o), 12'h002);
        checkOutput("t1_we1",     64'(bob_ch_we_o), 0);
        stepClock();
        checkOutput("t1_pc2",     bob_pc_r_o, 64'h1008);
        checkOutput("t1_bhr2",    64'(bob_bhr_r_o), 12'h003);
        checkOutput("t1_dir2",    64'(bob_ch_brdir_o), 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("t1_empty_valid", 64'(bob_valid_r_o), 0);
        checkOutput("t1_empty_pc",    bob_pc_r_o, 0);
        checkOutput("t1_empty_bhr",   64'(bob_bhr_r_o), 0);
        checkOutput("t1_empty_count", 64'(bob_count_o), 0);
        stepClock();
        checkOutput("t1_retire_empty_count", 64'(bob_count_o), 0);
        checkOutput("t1_retire_empty_tag",   64'(alloc_tag_o), 3);

        // Flush to realign pointers, then fill to full
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_flush_tag", 64'(alloc_tag_o), 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 64'h2000 + 64'(i), 12'(i), 10'(i), 0, 0, 0, 0);
            checkOutput("t2_fill_tag", 64'(alloc_tag_o), 64'(i));
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_full_count", 64'(bob_count_o), 16);
        checkOutput("t2_full_rdy",   64'(alloc_rdy_o), 0);
        checkOutput("t2_full_tag",   64'(alloc_tag_o), 0);
        applyStimulus(1, 64'h2fff, 12'hfff, 10'h3ff, 1, 1, 0, 0);
        checkOutput("t2_drop_rdy", 64'(alloc_rdy_o), 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_drop_count", 64'(bob_count_o), 16);
        checkOutput("t2_drop_head",  bob_pc_r_o, 64'h2000);
        applyStimulus(1, 64'h2100, 12'h100, 10'h100, 1, 0, 1, 0);
        checkOutput("t2_full_rt_rdy", 64'(alloc_rdy_o), 1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_swap_count", 64'(bob_count_o), 16);
        checkOutput("t2_swap_tag",   64'(alloc_tag_o), 1);
        checkOutput("t2_swap_head",  bob_pc_r_o, 64'h2001);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("t2_full_flush_rdy", 64'(alloc_rdy_o), 0);
        stepClock();

        // Allocate plus retire into an empty buffer keeps the entry
        applyStimulus(1, 64'h3000, 12'h0aa, 10'h155, 1, 0, 1, 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_count", 64'(bob_count_o), 1);
        checkOutput("t3_valid", 64'(bob_valid_r_o), 1);
        checkOutput("t3_pc",    bob_pc_r_o, 64'h3000);

        // Flush with retire and allocate after building five entries
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1, 64'h3000 + 64'(4 * i), 12'h0a0 + 12'(i), 10'(i), 0, 0, 0, 0);
            stepClock();
        end
        applyStimulus(1, 64'h3fff, 12'h777, 10'h077, 1, 1, 1, 1);
        checkOutput("t4_count_pre", 64'(bob_count_o), 5);
        checkOutput("t4_bhr_vis",   64'(bob_bhr_r_o), 12'h0aa);
        checkOutput("t4_pc_vis",    bob_pc_r_o, 64'h3000);
        stepClock();
        applyStimulus(1, 64'h3100, 12'h111, 10'h011, 0, 0, 0, 1);
        checkOutput("t4_count", 64'(bob_count_o), 0);
        checkOutput("t4_tag",   64'(alloc_tag_o), 0);
        checkOutput("t4_valid", 64'(bob_valid_r_o), 0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_discard_count", 64'(bob_count_o), 0);
        checkOutput("t4_discard_pc",    bob_pc_r_o, 0);

        // Wrap stress against a scoreboard
        for (int i = 0; i < 40; i++) begin
            new_e.pc       = {$urandom, $urandom};
            new_e.bhr      = 12'($urandom);
            new_e.lochist  = 10'($urandom);
            new_e.ch_we    = 1'($urandom);
            new_e.ch_brdir = 1'($urandom);
            applyStimulus(1, new_e.pc, new_e.bhr, new_e.lochist, new_e.ch_we, new_e.ch_brdir, 0, 0);
            checkOutput("t5_tag", 64'(alloc_tag_o), 64'(i % 16));
            model_q.push_back(new_e);
            stepClock();
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
            exp_e = model_q.pop_front();
            checkOutput("t5_valid", 64'(bob_valid_r_o), 1);
            checkOutput("t5_pc",    bob_pc_r_o, exp_e.pc);
            checkOutput("t5_bhr",   64'(bob_bhr_r_o), 64'(exp_e.bhr));
            checkOutput("t5_lh",    64'(bob_lochist_o), 64'(exp_e.lochist));
            checkOutput("t5_we",    64'(bob_ch_we_o), 64'(exp_e.ch_we));
            checkOutput("t5_dir",   64'(bob_ch_brdir_o), 64'(exp_e.ch_brdir));
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_end_count", 64'(bob_count_o), 0);
        checkOutput("t5_end_tag",   64'(alloc_tag_o), 8);

        // Asynchronous reset with seven entries present
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 64'h6000 + 64'(i), 12'h600, 10'h060, 1, 1, 0, 0);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_count_pre", 64'(bob_count_o), 7);
        checkOutput("t6_pc_pre",    bob_pc_r_o, 64'h6000);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", 64'(bob_valid_r_o), 0);
        checkOutput("t6_async_count", 64'(bob_count_o), 0);
        checkOutput("t6_async_pc",    bob_pc_r_o, 0);
        checkOutput("t6_async_bhr",   64'(bob_bhr_r_o), 0);
        stepClock();
        reset_n = 1'b1;
        stepClock();
        checkOutput("t6_rel_rdy",   64'(alloc_rdy_o), 1);
        checkOutput("t6_rel_count", 64'(bob_count_o), 0);
        checkOutput("t6_rel_tag",   64'(alloc_tag_o), 0);
        checkOutput("t6_rel_valid", 64'(bob_valid_r_o), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
